// File: rtl/weight_fetch_if.sv
// ROM read port plus PE weight stream for one weight_fetch instance.
// Master is the fetcher; slave is the ROM/PE side.
interface weight_fetch_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 72
);
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  logic [DATA_W-1:0] rom_dout;
  logic              w_valid;
  logic              w_ready;
  logic [DATA_W-1:0] w_data;
  logic              w_last;

  modport master (
    output rom_addr, rom_en, w_valid, w_data, w_last,
    input  rom_dout, w_ready
  );

  modport slave (
    input  rom_addr, rom_en, w_valid, w_data, w_last,
    output rom_dout, w_ready
  );
endinterface

// File: rtl/weight_fetch.sv
// Weight ROM read initiator: issues a run of consecutive reads and streams the
// words to a PE through a small FIFO sized so reads never stall mid-flight.
module weight_fetch #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 72,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              busy,
  output logic              done,
  weight_fetch_if.master    bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFin} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic              inflight_q;
  logic              tag_inflight_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              tag_mem [DEPTH];

  logic              issue;
  logic              push;
  logic              pop;
  logic              room;
  logic [SUM_W-1:0]  occupancy;

  // Reserve a slot for the word still in flight from the ROM.
  assign occupancy = SUM_W'(count_q) + SUM_W'(inflight_q);
  assign room      = occupancy < SUM_W'(DEPTH);

  assign push = inflight_q;
  assign pop  = bus.w_valid & bus.w_ready;

  assign bus.w_valid  = (count_q != '0);
  assign bus.w_data   = bus.w_valid ? mem[rd_ptr_q] : '0;
  assign bus.w_last   = bus.w_valid & tag_mem[rd_ptr_q];
  assign bus.rom_addr = addr_q;
  assign bus.rom_en   = issue;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    issue       = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = num_words;
          state_d     = (num_words == '0) ? StFin : StFetch;
        end
      end
      StFetch: begin
        busy = 1'b1;
        if (room) begin
          issue       = 1'b1;
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - ADDR_W'(1);
          if (remaining_q == ADDR_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        if (pop && bus.w_last) state_d = StFin;
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      remaining_q    <= '0;
      inflight_q     <= 1'b0;
      tag_inflight_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      remaining_q    <= remaining_d;
      inflight_q     <= issue;
      tag_inflight_q <= issue && (remaining_q == ADDR_W'(1));
      count_q        <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: outputs are gated by w_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q]     <= bus.rom_dout;
      tag_mem[wr_ptr_q] <= tag_inflight_q;
    end
  end

endmodule

// File: tb/tb_weight_fetch.sv
// Self-checking bench for weight_fetch: directed timing runs plus randomized
// runs scored against an address/word-order reference model.
module tb_weight_fetch;
  localparam int AW = 14;
  localparam int DW = 72;
  localparam int DEPTH = 4;
  localparam int MAXC = 160;

  logic          clk = 1'b0;
  logic          rst, start, busy, done;
  logic [AW-1:0] base_addr, num_words;

  weight_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  weight_fetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {18'd0, a} * 32'h9E3779B1;
    return {a, h, a[7:0] ^ 8'hA5, a, 4'hC};
  endfunction

  // Synchronous-read ROM model
  always @(posedge clk) if (bus.rom_en) bus.rom_dout <= rom_word(bus.rom_addr);

  logic          rec_en [MAXC], rec_valid [MAXC], rec_ready [MAXC], rec_last [MAXC];
  logic          rec_busy [MAXC], rec_done [MAXC];
  logic [AW-1:0] rec_addr [MAXC];
  logic [DW-1:0] rec_data [MAXC];

  int            hs_n, is_n, done_n, done_cyc;
  int            hs_cyc [MAXC];
  logic [DW-1:0] hs_data [MAXC];
  logic          hs_last [MAXC];
  logic [AW-1:0] is_addr [MAXC];

  // Drives one run from cycle 0 (start) and records every cycle's outputs.
  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] n, input int mode,
                     input int restart_cyc, input int rst_cyc, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start     = (c == 0) || (c == restart_cyc);
      base_addr = (c == restart_cyc) ? b + 14'h100 : b;
      num_words = (c == restart_cyc) ? 14'd3 : n;
      rst       = (c == rst_cyc);
      case (mode)
        0:       bus.w_ready = 1'b1;
        1:       bus.w_ready = (c > 12);
        default: bus.w_ready = ($urandom_range(0, 9) < 6);
      endcase
      #1;
      rec_en[c] = bus.rom_en;       rec_addr[c] = bus.rom_addr;
      rec_valid[c] = bus.w_valid;   rec_ready[c] = bus.w_ready;
      rec_data[c] = bus.w_data;     rec_last[c] = bus.w_last;
      rec_busy[c] = busy;           rec_done[c] = done;
      @(posedge clk); #1;
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic extract(input int ncyc);
    hs_n = 0; is_n = 0; done_n = 0; done_cyc = -1;
    for (int c = 0; c < ncyc; c++) begin
      if (rec_valid[c] && rec_ready[c]) begin
        hs_data[hs_n] = rec_data[c]; hs_last[hs_n] = rec_last[c]; hs_cyc[hs_n] = c;
        hs_n++;
      end
      if (rec_en[c]) begin
        is_addr[is_n] = rec_addr[c];
        is_n++;
      end
      if (rec_done[c]) begin
        if (done_n == 0) done_cyc = c;
        done_n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++; if ({busy, done, bus.rom_en, bus.w_valid, bus.w_last} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b want=00000",
                      {busy, done, bus.rom_en, bus.w_valid, bus.w_last});
    end
    total++; if (bus.rom_addr !== '0) begin
      bad++; $display("FAIL reset_addr got=%h want=0", bus.rom_addr);
    end
    total++; if (bus.w_data !== '0) begin
      bad++; $display("FAIL reset_data got=%h want=0", bus.w_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic exp_en, exp_valid;
    run(14'h0010, 14'd5, 0, -1, -1, 14);
    for (int c = 0; c < 14; c++) begin
      exp_en = (c >= 1 && c <= 5);
      exp_valid = (c >= 3 && c <= 7);
      total++; if (rec_en[c] !== exp_en) begin
        bad++; $display("FAIL basic_en c=%0d got=%b want=%b", c, rec_en[c], exp_en);
      end
      if (exp_en) begin
        total++; if (rec_addr[c] !== AW'(16 + c - 1)) begin
          bad++; $display("FAIL basic_addr c=%0d got=%h want=%h", c, rec_addr[c], 16 + c - 1);
        end
      end
      total++; if (rec_valid[c] !== exp_valid || rec_last[c] !== (c == 7)) begin
        bad++; $display("FAIL basic_valid_last c=%0d got=%b%b want=%b%b", c, rec_valid[c],
                        rec_last[c], exp_valid, c == 7);
      end
      if (exp_valid) begin
        total++; if (rec_data[c] !== rom_word(AW'(16 + c - 3))) begin
          bad++; $display("FAIL basic_data c=%0d got=%h want=%h", c, rec_data[c],
                          rom_word(AW'(16 + c - 3)));
        end
      end
      total++; if (rec_done[c] !== (c == 8)) begin
        bad++; $display("FAIL basic_done c=%0d got=%b want=%b", c, rec_done[c], c == 8);
      end
      if (c != 8) begin
        total++; if (rec_busy[c] !== (c >= 1 && c <= 7)) begin
          bad++; $display("FAIL basic_busy c=%0d got=%b want=%b", c, rec_busy[c],
                          c >= 1 && c <= 7);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int early;
    run(14'h0010, 14'd5, 1, -1, -1, 30);
    extract(30);
    early = 0;
    for (int c = 0; c <= 12; c++) if (rec_en[c]) early++;
    total++; if (early != 4 || is_n != 5) begin
      bad++; $display("FAIL bp_reads got early=%0d total=%0d want 4/5", early, is_n);
    end
    for (int i = 0; i < is_n && i < 5; i++) begin
      total++; if (is_addr[i] !== AW'(16 + i)) begin
        bad++; $display("FAIL bp_addr i=%0d got=%h want=%h", i, is_addr[i], 16 + i);
      end
    end
    for (int c = 3; c <= 12; c++) begin
      total++; if (rec_valid[c] !== 1'b1 || rec_data[c] !== rom_word(14'h10) || rec_last[c]) begin
        bad++; $display("FAIL bp_hold c=%0d got v=%b d=%h want v=1 d=%h", c, rec_valid[c],
                        rec_data[c], rom_word(14'h10));
      end
    end
    total++; if (hs_n != 5) begin
      bad++; $display("FAIL bp_words got=%0d want=5", hs_n);
    end
    for (int i = 0; i < hs_n && i < 5; i++) begin
      total++; if (hs_data[i] !== rom_word(AW'(16 + i)) || hs_last[i] !== (i == 4)) begin
        bad++; $display("FAIL bp_word i=%0d got=%h/%b want=%h/%b", i, hs_data[i], hs_last[i],
                        rom_word(AW'(16 + i)), i == 4);
      end
    end
    total++; if (done_n != 1 || (hs_n == 5 && done_cyc != hs_cyc[4] + 1)) begin
      bad++; $display("FAIL bp_done got n=%0d cyc=%0d want one after last handshake",
                      done_n, done_cyc);
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    run(14'h3FFE, 14'd4, 0, -1, -1, 12);
    extract(12);
    total++; if (is_n != 4 || hs_n != 4) begin
      bad++; $display("FAIL wrap_count got reads=%0d words=%0d want 4/4", is_n, hs_n);
    end
    for (int i = 0; i < 4; i++) begin
      a = 14'h3FFE + AW'(i);
      total++; if (is_addr[i] !== a || hs_data[i] !== rom_word(a)) begin
        bad++; $display("FAIL wrap_addr i=%0d got=%h want=%h", i, is_addr[i], a);
      end
    end
    total++; if (done_cyc != 7) begin
      bad++; $display("FAIL wrap_done got=%0d want=7", done_cyc);
    end
  endtask

  task automatic test_zero();
    run(14'h0055, 14'd0, 0, -1, -1, 6);
    for (int c = 0; c < 6; c++) begin
      total++; if ({rec_done[c], rec_en[c], rec_valid[c], rec_busy[c]} !== {c == 1, 3'b000}) begin
        bad++; $display("FAIL zero c=%0d got done/en/valid/busy=%b%b%b%b want=%b000", c,
                        rec_done[c], rec_en[c], rec_valid[c], rec_busy[c], c == 1);
      end
    end
  endtask

  task automatic test_restart();
    run(14'h0100, 14'd6, 0, 2, -1, 14);
    extract(14);
    total++; if (is_n != 6 || hs_n != 6) begin
      bad++; $display("FAIL restart_count got reads=%0d words=%0d want 6/6", is_n, hs_n);
    end
    for (int i = 0; i < is_n && i < 6; i++) begin
      total++; if (is_addr[i] !== AW'(256 + i)) begin
        bad++; $display("FAIL restart_addr i=%0d got=%h want=%h", i, is_addr[i], 256 + i);
      end
    end
    total++; if (done_n != 1 || done_cyc != 9) begin
      bad++; $display("FAIL restart_done got n=%0d cyc=%0d want 1/9", done_n, done_cyc);
    end
  endtask

  task automatic test_reset_midrun();
    run(14'h0040, 14'd10, 0, -1, 4, 12);
    extract(12);
    total++; if ({rec_busy[4], rec_done[4], rec_en[4], rec_valid[4], rec_last[4]} !== 5'b0 ||
                 rec_addr[4] !== '0 || rec_data[4] !== '0) begin
      bad++; $display("FAIL midrst_outputs got ctrl=%b addr=%h want all zero",
                      {rec_busy[4], rec_done[4], rec_en[4], rec_valid[4], rec_last[4]},
                      rec_addr[4]);
    end
    total++; if (done_n != 0 || is_n != 3) begin
      bad++; $display("FAIL midrst_abort got done=%0d reads=%0d want 0/3", done_n, is_n);
    end
    run(14'h0080, 14'd3, 0, -1, -1, 10);
    extract(10);
    total++; if (is_n != 3 || hs_n != 3 || done_cyc != 6) begin
      bad++; $display("FAIL midrst_rerun got reads=%0d words=%0d done=%0d want 3/3/6",
                      is_n, hs_n, done_cyc);
    end
    for (int i = 0; i < hs_n && i < 3; i++) begin
      total++; if (is_addr[i] !== AW'(128 + i) || hs_data[i] !== rom_word(AW'(128 + i))) begin
        bad++; $display("FAIL midrst_word i=%0d got=%h want=%h", i, is_addr[i], 128 + i);
      end
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] b, a;
    int n, iss, pops, occ_bad, hold_bad;
    for (int r = 0; r < 8; r++) begin
      b = AW'($urandom);
      n = $urandom_range(1, 12);
      run(b, AW'(n), 2, -1, -1, 150);
      extract(150);
      total++; if (is_n != n || hs_n != n) begin
        bad++; $display("FAIL rnd_count r=%0d got reads=%0d words=%0d want %0d", r, is_n, hs_n, n);
      end
      for (int i = 0; i < n && i < hs_n && i < is_n; i++) begin
        a = b + AW'(i);
        total++; if (is_addr[i] !== a || hs_data[i] !== rom_word(a) || hs_last[i] !== (i == n - 1))
        begin
          bad++; $display("FAIL rnd_word r=%0d i=%0d got a=%h last=%b want a=%h last=%b", r, i,
                          is_addr[i], hs_last[i], a, i == n - 1);
        end
      end
      total++; if (done_n != 1 || (hs_n > 0 && done_cyc != hs_cyc[hs_n - 1] + 1)) begin
        bad++; $display("FAIL rnd_done r=%0d got n=%0d cyc=%0d", r, done_n, done_cyc);
      end
      iss = 0; pops = 0; occ_bad = 0; hold_bad = 0;
      for (int c = 0; c < 150; c++) begin
        iss += int'(rec_en[c]);
        if (iss - pops > DEPTH) occ_bad++;
        if (rec_valid[c] && rec_ready[c]) pops++;
        if (c > 0 && rec_valid[c - 1] && !rec_ready[c - 1] &&
            (!rec_valid[c] || rec_data[c] !== rec_data[c - 1] || rec_last[c] !== rec_last[c - 1]))
          hold_bad++;
      end
      total++; if (occ_bad != 0) begin
        bad++; $display("FAIL rnd_overrun r=%0d got=%0d cycles want=0", r, occ_bad);
      end
      total++; if (hold_bad != 0) begin
        bad++; $display("FAIL rnd_hold r=%0d got=%0d unstable cycles want=0", r, hold_bad);
      end
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; base_addr = '0; num_words = '0; bus.w_ready = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero();
    test_restart();
    test_reset_midrun();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
